// File: rtl/nested_affine_agen_if.sv
// Scheduler-to-address-generator bus for nested_affine_agen.
// Handshake: an address transfers on a rising edge where addr_valid && step; addr_out holds until then.
interface nested_affine_agen_if #(
  parameter int WIDTH = 16,
  parameter int DIMS  = 3
);
  logic                       start;
  logic [$clog2(DIMS+1)-1:0]  cfg_dims;
  logic [WIDTH-1:0]           cfg_offset;
  logic [DIMS*WIDTH-1:0]      cfg_extent;
  logic [DIMS*WIDTH-1:0]      cfg_stride;
  logic                       step;
  logic [WIDTH-1:0]           addr_out;
  logic                       addr_valid;
  logic                       last;
  logic                       busy;
  logic                       done;

  modport master (
    output start, cfg_dims, cfg_offset, cfg_extent, cfg_stride, step,
    input  addr_out, addr_valid, last, busy, done
  );

  modport slave (
    input  start, cfg_dims, cfg_offset, cfg_extent, cfg_stride, step,
    output addr_out, addr_valid, last, busy, done
  );
endinterface

// File: rtl/nested_affine_agen.sv
// Nested-loop affine address generator: offset + sum(i_k * stride_k), one address per accepted step.
// Optional NESTED_AGEN_REPEAT_EN: the sweep restarts forever instead of returning to IDLE.
module nested_affine_agen #(
  parameter int WIDTH = 16,
  parameter int DIMS  = 3
) (
  input  logic                clk,
  input  logic                rst,
  nested_affine_agen_if.slave bus,
  output logic                dbg_state
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q    [DIMS];
  logic [WIDTH-1:0] base_q   [DIMS];
  logic [WIDTH-1:0] ext_m1_q [DIMS];
  logic [WIDTH-1:0] stride_q [DIMS];
  logic [WIDTH-1:0] offset_q;
  logic [DIMS-1:0]  act_q, cfg_act;
  logic             done_q;

  logic [DIMS-1:0]  sel_oh, lower;
  logic             found;
  logic [WIDTH-1:0] new_base;
  logic             accept, wrap, load;

  always_comb begin
    int dims_i;
    cfg_act = '0;
    dims_i  = int'(bus.cfg_dims);
    if (dims_i == 0 || dims_i > DIMS) dims_i = DIMS;
    for (int k = 0; k < DIMS; k++) cfg_act[k] = (k < dims_i);
  end

  // Lowest active level not yet at its final count; none found means the current address is the last.
  always_comb begin
    found    = 1'b0;
    sel_oh   = '0;
    lower    = '0;
    new_base = base_q[0];
    for (int k = 0; k < DIMS; k++) begin
      if (!found) begin
        if (act_q[k] && cnt_q[k] != ext_m1_q[k]) begin
          found     = 1'b1;
          sel_oh[k] = 1'b1;
          new_base  = base_q[k] + stride_q[k];
        end else begin
          lower[k] = 1'b1;
        end
      end
    end
  end

  assign accept = (state_q == RUN) && bus.step;
  assign wrap   = accept && !found;
  assign load   = (state_q == IDLE) && bus.start;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.start) state_d = RUN;
      RUN: begin
`ifdef NESTED_AGEN_REPEAT_EN
        state_d = RUN;
`else
        if (wrap) state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done_q   <= 1'b0;
      offset_q <= '0;
      act_q    <= '0;
      for (int k = 0; k < DIMS; k++) begin
        cnt_q[k]    <= '0;
        base_q[k]   <= '0;
        ext_m1_q[k] <= '0;
        stride_q[k] <= '0;
      end
    end else begin
      done_q <= wrap;
      if (load) begin
        offset_q <= bus.cfg_offset;
        act_q    <= cfg_act;
        for (int k = 0; k < DIMS; k++) begin
          cnt_q[k]    <= '0;
          base_q[k]   <= bus.cfg_offset;
          stride_q[k] <= bus.cfg_stride[k*WIDTH +: WIDTH];
          // Extent 0 behaves as a single trip, same as extent 1.
          ext_m1_q[k] <= (bus.cfg_extent[k*WIDTH +: WIDTH] == '0) ? '0
                       : bus.cfg_extent[k*WIDTH +: WIDTH] - WIDTH'(1);
        end
      end else if (wrap) begin
        for (int k = 0; k < DIMS; k++) begin
          cnt_q[k] <= '0;
`ifdef NESTED_AGEN_REPEAT_EN
          base_q[k] <= offset_q;
`else
          base_q[k] <= '0;
`endif
        end
      end else if (accept) begin
        for (int k = 0; k < DIMS; k++) begin
          if (sel_oh[k]) begin
            cnt_q[k]  <= cnt_q[k] + WIDTH'(1);
            base_q[k] <= new_base;
          end else if (lower[k]) begin
            cnt_q[k]  <= '0;
            base_q[k] <= new_base;
          end
        end
      end
    end
  end

  assign bus.addr_out   = base_q[0];
  assign bus.addr_valid = (state_q == RUN);
  assign bus.busy       = (state_q == RUN);
  assign bus.last       = (state_q == RUN) && !found;
  assign bus.done       = done_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_nested_affine_agen.sv
// Directed table-driven bench for nested_affine_agen with an accepted-address scoreboard.
module tb_nested_affine_agen;
  localparam int W = 16;
  localparam int D = 3;

  logic clk;
  logic rst;
  logic dbg_state;

  nested_affine_agen_if #(.WIDTH(W), .DIMS(D)) ag ();

  nested_affine_agen #(.WIDTH(W), .DIMS(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (ag.slave),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && ag.step && ag.addr_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_extra actual=%0h expected=none", ag.addr_out);
      end else begin
        check("sb_addr", ag.addr_out, exp_q.pop_front());
      end
    end
  end

  // ---------------- vectors ----------------
  typedef struct {
    logic         rst;
    logic [1:0]   start;   // 0 none, 1 start with test config, 2 start with junk config
    logic         step;
    logic [W-1:0] addr;
    logic         valid;
    logic         last;
    logic         done;
  } vec_t;

  vec_t vecs[$];

  logic [1:0]     cfg_d;
  logic [W-1:0]   cfg_o;
  logic [D*W-1:0] cfg_e;
  logic [D*W-1:0] cfg_s;

  function automatic void add(input logic r, input logic [1:0] s, input logic st,
                              input logic [W-1:0] a, input logic v, input logic l, input logic d);
    vec_t t;
    t = '{r, s, st, a, v, l, d};
    vecs.push_back(t);
  endfunction

  task automatic set_cfg(input logic [1:0] dm, input logic [W-1:0] off,
                         input logic [D*W-1:0] ext, input logic [D*W-1:0] str);
    cfg_d = dm; cfg_o = off; cfg_e = ext; cfg_s = str;
  endtask

  task automatic drive_junk_cfg();
    logic [63:0] r1, r2;
    r1 = {$urandom, $urandom};
    r2 = {$urandom, $urandom};
    ag.cfg_dims   = 2'($urandom_range(0, 3));
    ag.cfg_offset = W'($urandom_range(0, 16'hffff));
    ag.cfg_extent = r1[D*W-1:0];
    ag.cfg_stride = r2[D*W-1:0];
  endtask

  task automatic apply_vecs(input string tag);
    for (int i = 0; i < vecs.size(); i++) begin
      rst     = vecs[i].rst;
      ag.step = vecs[i].step;
      ag.start = (vecs[i].start != 2'd0);
      if (vecs[i].start == 2'd1) begin
        ag.cfg_dims = cfg_d; ag.cfg_offset = cfg_o;
        ag.cfg_extent = cfg_e; ag.cfg_stride = cfg_s;
      end else begin
        drive_junk_cfg();
      end
      #1;
      check($sformatf("%s[%0d].valid", tag, i), ag.addr_valid, vecs[i].valid);
      check($sformatf("%s[%0d].busy",  tag, i), ag.busy,       vecs[i].valid);
      check($sformatf("%s[%0d].last",  tag, i), ag.last,       vecs[i].last);
      check($sformatf("%s[%0d].done",  tag, i), ag.done,       vecs[i].done);
      if (vecs[i].valid)
        check($sformatf("%s[%0d].addr", tag, i), ag.addr_out, vecs[i].addr);
      @(posedge clk); #1;
    end
    vecs.delete();
    ag.step  = 1'b0;
    ag.start = 1'b0;
  endtask

  task automatic push_addrs(input logic [W-1:0] a[]);
    foreach (a[i]) exp_q.push_back(a[i]);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    ag.start = 1'b0; ag.step = 1'b0;
    ag.cfg_dims = '0; ag.cfg_offset = '0; ag.cfg_extent = '0; ag.cfg_stride = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.valid", ag.addr_valid, 0);
    check("reset.busy",  ag.busy,       0);
    check("reset.last",  ag.last,       0);
    check("reset.done",  ag.done,       0);
    check("reset.addr",  ag.addr_out,   0);

`ifdef NESTED_AGEN_REPEAT_EN
    set_cfg(2'd1, 16'd7, {16'd0, 16'd0, 16'd2}, {16'd0, 16'd0, 16'd3});
    push_addrs('{16'd7, 16'd10, 16'd7, 16'd10});
    add(0, 1, 0, 16'd0,  0, 0, 0);
    add(0, 0, 1, 16'd7,  1, 0, 0);
    add(0, 0, 1, 16'd10, 1, 1, 0);
    add(0, 0, 1, 16'd7,  1, 0, 1);
    add(0, 0, 1, 16'd10, 1, 1, 0);
    add(0, 0, 0, 16'd7,  1, 0, 1);
    add(0, 0, 0, 16'd7,  1, 0, 0);
    apply_vecs("repeat");
`else
    // Two levels, step held high.
    set_cfg(2'd2, 16'd100, {16'd0, 16'd2, 16'd3}, {16'd0, 16'd10, 16'd1});
    push_addrs('{16'd100, 16'd101, 16'd102, 16'd110, 16'd111, 16'd112});
    add(0, 1, 0, 16'd0,   0, 0, 0);
    add(0, 0, 1, 16'd100, 1, 0, 0);
    add(0, 0, 1, 16'd101, 1, 0, 0);
    add(0, 0, 1, 16'd102, 1, 0, 0);
    add(0, 0, 1, 16'd110, 1, 0, 0);
    add(0, 0, 1, 16'd111, 1, 0, 0);
    add(0, 0, 1, 16'd112, 1, 1, 0);
    add(0, 0, 1, 16'd0,   0, 0, 1);
    add(0, 0, 0, 16'd0,   0, 0, 0);
    apply_vecs("full");

    // Stalled stepping with start pulses (junk config) mid-sweep.
    push_addrs('{16'd100, 16'd101, 16'd102, 16'd110, 16'd111, 16'd112});
    add(0, 1, 0, 16'd0,   0, 0, 0);
    add(0, 0, 1, 16'd100, 1, 0, 0);
    add(0, 0, 0, 16'd101, 1, 0, 0);
    add(0, 2, 0, 16'd101, 1, 0, 0);
    add(0, 0, 1, 16'd101, 1, 0, 0);
    add(0, 2, 1, 16'd102, 1, 0, 0);
    add(0, 0, 0, 16'd110, 1, 0, 0);
    add(0, 0, 0, 16'd110, 1, 0, 0);
    add(0, 0, 1, 16'd110, 1, 0, 0);
    add(0, 0, 1, 16'd111, 1, 0, 0);
    add(0, 0, 0, 16'd112, 1, 1, 0);
    add(0, 0, 0, 16'd112, 1, 1, 0);
    add(0, 0, 1, 16'd112, 1, 1, 0);
    add(0, 0, 0, 16'd0,   0, 0, 1);
    apply_vecs("stall");

    // Three levels, middle extent 0 acts as 1.
    set_cfg(2'd3, 16'd0, {16'd2, 16'd0, 16'd2}, {16'd1000, 16'd100, 16'd4});
    push_addrs('{16'd0, 16'd4, 16'd1000, 16'd1004});
    add(0, 1, 0, 16'd0,    0, 0, 0);
    add(0, 0, 1, 16'd0,    1, 0, 0);
    add(0, 0, 1, 16'd4,    1, 0, 0);
    add(0, 0, 1, 16'd1000, 1, 0, 0);
    add(0, 0, 1, 16'd1004, 1, 1, 0);
    add(0, 0, 0, 16'd0,    0, 0, 1);
    apply_vecs("dims3");

    // Address wrap, then reset mid-sweep (no done), then restart.
    set_cfg(2'd1, 16'hFFFE, {16'd9, 16'd9, 16'd4}, {16'd5, 16'd5, 16'd1});
    push_addrs('{16'hFFFE, 16'hFFFF, 16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001});
    add(0, 1, 0, 16'h0000, 0, 0, 0);
    add(0, 0, 1, 16'hFFFE, 1, 0, 0);
    add(0, 0, 1, 16'hFFFF, 1, 0, 0);
    add(1, 0, 0, 16'h0000, 1, 0, 0);
    add(0, 0, 0, 16'h0000, 0, 0, 0);
    add(0, 1, 0, 16'h0000, 0, 0, 0);
    add(0, 0, 1, 16'hFFFE, 1, 0, 0);
    add(0, 0, 1, 16'hFFFF, 1, 0, 0);
    add(0, 0, 1, 16'h0000, 1, 0, 0);
    add(0, 0, 1, 16'h0001, 1, 1, 0);
    add(0, 0, 0, 16'h0000, 0, 0, 1);
    apply_vecs("wrap");

    // Negative stride; then cfg_dims=0 meaning all levels, extra extents 1.
    set_cfg(2'd1, 16'd5, {16'd7, 16'd7, 16'd3}, {16'd9, 16'd9, 16'hFFFF});
    push_addrs('{16'd5, 16'd4, 16'd3});
    add(0, 1, 0, 16'd0, 0, 0, 0);
    add(0, 0, 1, 16'd5, 1, 0, 0);
    add(0, 0, 1, 16'd4, 1, 0, 0);
    add(0, 0, 1, 16'd3, 1, 1, 0);
    add(0, 0, 0, 16'd0, 0, 0, 1);
    apply_vecs("neg");

    set_cfg(2'd0, 16'd5, {16'd1, 16'd1, 16'd3}, {16'd88, 16'd77, 16'hFFFF});
    push_addrs('{16'd5, 16'd4, 16'd3});
    add(0, 1, 0, 16'd0, 0, 0, 0);
    add(0, 0, 1, 16'd5, 1, 0, 0);
    add(0, 0, 1, 16'd4, 1, 0, 0);
    add(0, 0, 1, 16'd3, 1, 1, 0);
    add(0, 0, 1, 16'd0, 0, 0, 1);
    add(0, 0, 0, 16'd0, 0, 0, 0);
    apply_vecs("dims0");
`endif

    check("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nested_affine_agen.md
# nested_affine_agen

Parametrised nested-loop affine address generator for the frail address-generation path. It emits `offset + sum(i_k * stride_k)` over up to `DIMS` nested loop levels with runtime extents and strides. It advances one address per accepted `step`, and has an explicit start/busy/done lifecycle. It sits between the scheduler that issues `start`/`step` and the memory port that consumes `addr_out`. It replaces hand-built per-loop scan chains with a single configurable block.

## Interface
Parameters:
- `WIDTH`, 16, width of addresses, extents and strides
- `DIMS`, 3, number of loop levels; level 0 is innermost; must be ≥1

Ports:
- `clk`  input  1  clock; all state updates on its rising edge
- `rst`  input  1  reset; synchronous, active-high
- `start`  input  1  latch configuration and begin a sweep; honoured only in IDLE
- `cfg_dims`  input  $clog2(DIMS+1)  number of active levels, 1..DIMS; 0 or >DIMS is treated as DIMS
- `cfg_offset`  input  WIDTH  base address
- `cfg_extent`  input  DIMS*WIDTH  per-level trip count; level k occupies bits [k*WIDTH +: WIDTH]
- `cfg_stride`  input  DIMS*WIDTH  per-level stride, packed the same way as `cfg_extent`
- `step`  input  1  consumer accepts the current address
- `addr_out`  output  WIDTH  current address
- `addr_valid`  output  1  `addr_out` is meaningful
- `last`  output  1  current address is the final one of the sweep
- `busy`  output  1  sweep in progress
- `done`  output  1  single-cycle pulse after the final address is accepted

## Operation
- States: IDLE and RUN.
- IDLE:
  - `start` latches all `cfg_*` inputs into shadow registers.
  - Per-level counters are cleared.
  - Base registers `base[k]` are loaded with `cfg_offset` for all k.
  - The block moves to RUN.
- RUN:
  - `addr_valid = 1` and `addr_out = base[0]`.
  - An accepted step (`step & addr_valid`) selects the lowest level k < active dims whose counter is not at `extent_k - 1`.
  - Counter k increments and all lower counters clear.
  - `base[k] += stride_k`, and every `base[j<k]` is set to the new `base[k]`.
- Completion:
  - `last` is asserted when every active counter is at `extent - 1`.
  - An accepted step while `last` is high moves the block to IDLE and pulses `done` for one cycle.
- Extent 0 is treated as 1.
- A sweep produces exactly `prod(max(extent_k,1))` addresses over the active levels.
- Arithmetic is modulo 2^WIDTH. Overflow wraps silently; strides are unsigned, so two's-complement values give negative strides.
- Levels ≥ active dims are ignored entirely.
- `start` during RUN is ignored. Shadow configuration is immutable during a sweep.
- `step` in IDLE is ignored.
- `rst` at any time, including mid-sweep, forces IDLE and clears all counters and bases. `done` is not pulsed.
- Reset values: `addr_out = 0`, `addr_valid = 0`, `last = 0`, `busy = 0`, `done = 0`.

## Timing
- `start` sampled at edge t gives `addr_valid = 1` and `addr_out = cfg_offset` from t+1. Latency is 1 cycle.
- An accepted step at edge t makes the next address visible from t+1. With `step` held high, throughput is one address per cycle.
- Without `step`, `addr_out` holds indefinitely.
- A final accepted step at edge t gives `addr_valid = 0`, `busy = 0` and `done = 1` during t+1 only.
- A new `start` is accepted at edge t+1 at the earliest.
- `busy` equals `addr_valid`. Both are registered.
- `last` is combinational from registered state only; it has no input-to-output path.

## Configuration
- `NESTED_AGEN_REPEAT_EN`
  - Defined: an accepted final step pulses `done` and stays in RUN. Counters clear and all bases reload to the latched offset, so the first address reappears at t+1. Only `rst` exits RUN.
  - Undefined: the sweep terminates to IDLE as described above.

## Test plan
- WIDTH=16, dims=2, extents {3,2}, strides {1,10}, offset 100, `step` held high → addresses 100,101,102,110,111,112 on consecutive cycles; `last` with 112; `done` the cycle after; then IDLE.
- Same configuration with `step` toggling 1,0,0,1 and a `start` pulse mid-sweep → address advances only on accepted steps, each value holds while stalled, `start` has no effect, sequence unchanged.
- dims=3, extents {2,0,2}, strides {4,100,1000}, offset 0 → 0,4,1000,1004 (level 1 extent 0 treated as 1), `done` after 1004.
- Offset 0xFFFE, extent {4}, stride {1} → FFFE,FFFF,0000,0001; `rst` asserted after the second address → `addr_valid` 0 next cycle, no `done`, restart yields FFFE.
- Stride 0xFFFF (-1), offset 5, extent {3} → 5,4,3; `cfg_dims` = 0 treated as DIMS with the extra levels' extents at 1 → same sequence.
- With `NESTED_AGEN_REPEAT_EN`, extents {2}, strides {3}, offset 7, `step` held high → 7,10,7,10… with `done` pulsing after each 10 and `addr_valid` never dropping.
